// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder:
//               FSM state encoding, default latency/depth and index width.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Default request-to-ack latency (legal 1..15) and storage depth in words
  localparam int unsigned LATENCY_DEF = 4;
  localparam int unsigned DEPTH_DEF   = 32;

  // Latency counter width; holds LATENCY-1 for the largest legal LATENCY
  localparam int unsigned CNT_W = 4;

  // Word-index width for a given depth, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned IDX_W_DEF = idx_width(DEPTH_DEF);

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Word storage for the data-memory responder. Synchronous
//               write, asynchronous read, synchronous clear of every word
//               while reset is held low.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Zero all words during reset; otherwise commit a full-word store
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Combinational read of the addressed word
  assign o_rdata = r_mem[i_addr];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency data-memory responder for a pipelined CPU.
//               Latches a request, counts LATENCY cycles, performs the word
//               access (with alignment/range fault check) and pulses ack_o.
//               stall_o freezes the pipeline while a request is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  dmem_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_ack;
  logic             r_err;
  logic [31:0]      r_rdata;

  logic             w_fault;
  logic             w_misaligned;
  logic             w_out_of_range;
  logic             w_access;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd_word;

  // Fault and index decode work from the latched address so the payload
  // may change freely once the request has been accepted.
  assign w_misaligned   = (r_addr[1:0] != 2'b00);
  assign w_out_of_range = ({2'b00, r_addr[31:2]} >= 32'(DEPTH));
  assign w_fault        = w_misaligned | w_out_of_range;
  assign w_idx          = r_addr[IDX_W+1:2];

  // The access happens on the last BUSY cycle; a faulting store never writes
  assign w_access = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_mem_we = w_access && r_we && !w_fault;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_mem_we),
    .i_addr  (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rd_word)
  );

  // Request FSM with latency counter and registered ack/err/rdata
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      // ack and err are single-cycle pulses unless re-asserted below
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= ST_RESP;
            r_ack   <= 1'b1;
            r_err   <= w_fault;
            // Loads update the held read data only when they do not fault
            if (!r_we && !w_fault) begin
              r_rdata <= w_rd_word;
            end
          end
        end
        ST_RESP: begin
          // Ack cycle: req_i is ignored; return to IDLE for the bubble cycle
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign rdata_o = r_rdata;

  // Pipeline freeze: any pending request not completing this cycle
  assign stall_o = req_i & ~r_ack;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Two instances
//               (LATENCY=4 and LATENCY=1) share payload signals. A vector
//               table drives accesses; expected responses are queued per
//               instance and compared when ack_o pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic        we;
  logic [31:0] addr, wdata;
  logic        ack0, ack1, stall0, stall1, err0, err1;
  logic [31:0] rdata0, rdata1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  vec_t tbl[11];

  dmem_responder #(.LATENCY(4), .DEPTH(32)) u_dut4 (
    .clk_i (clk), .rst_i (rst), .req_i (req0), .we_i (we),
    .addr_i (addr), .wdata_i (wdata), .ack_o (ack0), .rdata_o (rdata0),
    .stall_o (stall0), .err_o (err0)
  );

  dmem_responder #(.LATENCY(1), .DEPTH(32)) u_dut1 (
    .clk_i (clk), .rst_i (rst), .req_i (req1), .we_i (we),
    .addr_i (addr), .wdata_i (wdata), .ack_o (ack1), .rdata_o (rdata1),
    .stall_o (stall1), .err_o (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response monitor, LATENCY=4 instance
  always @(negedge clk) begin
    if (ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("dut4 unexpected ack", 32'(ack0), 32'(0));
      end else begin
        m0 = q0.pop_front();
        chk("dut4 err_o", 32'(err0), 32'(m0.err));
        chk("dut4 rdata_o", rdata0, m0.rdata);
      end
    end
  end

  // Response monitor, LATENCY=1 instance
  always @(negedge clk) begin
    if (ack1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected ack", 32'(ack1), 32'(0));
      end else begin
        m1 = q1.pop_front();
        chk("dut1 err_o", 32'(err1), 32'(m1.err));
        chk("dut1 rdata_o", rdata1, m1.rdata);
      end
    end
  end

  // One access: drive, check stall in the request cycle, then check ack
  // timing and stall per cycle after the accepting edge. Leaves req high
  // unless drop is set (request withdrawn right after acceptance).
  task automatic do_access(input int sel, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic e,
                           input logic [31:0] r, input bit drop,
                           input string nm);
    int   lat;
    int   scnt;
    logic ak, st;
    exp_t x;
    lat   = (sel != 0) ? 1 : 4;
    x.err = e;
    x.rdata = r;
    @(posedge clk); #1;
    we = w; addr = a; wdata = d;
    if (sel != 0) begin req1 = 1'b1; q1.push_back(x); end
    else          begin req0 = 1'b1; q0.push_back(x); end
    @(negedge clk);
    st = (sel != 0) ? stall1 : stall0;
    chk({nm, " stall in request cycle"}, 32'(st), 32'(1));
    @(posedge clk);
    if (drop) begin
      #1;
      if (sel != 0) req1 = 1'b0; else req0 = 1'b0;
    end
    scnt = 0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      ak = (sel != 0) ? ack1 : ack0;
      st = (sel != 0) ? stall1 : stall0;
      if (c <= lat) begin
        chk({nm, " ack before latency"}, 32'(ak), 32'(0));
        if (st === 1'b1) scnt++;
      end else begin
        chk({nm, " ack at latency"}, 32'(ak), 32'(1));
        chk({nm, " stall in ack cycle"}, 32'(st), 32'(0));
      end
    end
    chk({nm, " stall cycles"}, 32'(scnt), drop ? 32'(0) : 32'(lat));
  endtask

  task automatic drop_req(input int sel);
    @(posedge clk); #1;
    if (sel != 0) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {we, addr, wdata, expected err, expected held rdata}
    tbl[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 32'h06, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 32'h80, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 32'h80, 32'h12345678, 1'b1, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 32'h00, 32'h0,        1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h7C, 32'hA5A5A5A5, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h7C, 32'h0,        1'b0, 32'hA5A5A5A5};
    tbl[8]  = '{1'b1, 32'h06, 32'hFFFFFFFF, 1'b1, 32'hA5A5A5A5};
    tbl[9]  = '{1'b0, 32'h04, 32'h0,        1'b0, 32'h0};
    tbl[10] = '{1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF};

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack_o", 32'(ack0), 32'(0));
    chk("reset err_o", 32'(err0), 32'(0));
    chk("reset rdata_o", rdata0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Idle after reset release: nothing moves
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle ack_o", 32'(ack0 | ack1), 32'(0));
      chk("idle stall_o", 32'(stall0 | stall1), 32'(0));
      chk("idle rdata_o", rdata0 | rdata1, 32'h0);
    end

    // Table vectors on the LATENCY=4 instance
    for (int i = 0; i < 11; i++) begin
      do_access(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].err,
                tbl[i].rdata, 1'b0, $sformatf("vec%0d", i));
      drop_req(0);
    end

    // Back-to-back store then load with req held through the bubble
    do_access(0, 1'b1, 32'h0, 32'h1, 1'b0, 32'hDEADBEEF, 1'b0, "b2b store");
    do_access(0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1, 1'b0, "b2b load");
    drop_req(0);

    // Request withdrawn early: access still completes
    do_access(0, 1'b1, 32'h10, 32'h77, 1'b0, 32'h1, 1'b1, "early drop store");
    do_access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h77, 1'b0, "early drop load");
    drop_req(0);

    // Reset two cycles into a store: no ack, no write, storage cleared
    @(posedge clk); #1;
    req0 = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'h55;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1;
    @(negedge clk);
    chk("in reset stall_o", 32'(stall0), 32'(1));
    chk("in reset ack_o", 32'(ack0), 32'(0));
    chk("in reset rdata_o", rdata0, 32'h0);
    chk("in reset err_o", 32'(err0), 32'(0));
    @(posedge clk); #1;
    req0 = 1'b0; rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no ack after reset", 32'(ack0), 32'(0));
    end
    do_access(0, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0, 1'b0, "load 0xC after reset");
    drop_req(0);
    do_access(0, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0, 1'b0, "load 0x8 after reset");
    drop_req(0);

    // LATENCY=1 instance
    do_access(1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0, 1'b0, "lat1 load");
    drop_req(1);
    do_access(1, 1'b1, 32'h04, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, "lat1 store");
    drop_req(1);
    do_access(1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0BADF00D, 1'b0, "lat1 reload");
    drop_req(1);

    repeat (4) @(negedge clk);
    chk("dut4 responses outstanding", 32'(q0.size()), 32'(0));
    chk("dut1 responses outstanding", 32'(q1.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request sample to ack; legal range 1..15.
REQ-002 Parameter DEPTH, default 32, number of 32-bit words stored.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 req_i  input  1  CPU memory request; held high with stable payload until the ack cycle, inclusive.
REQ-006 we_i  input  1  1 = store word, 0 = load word.
REQ-007 addr_i  input  32  byte address from CPU ALU result.
REQ-008 wdata_i  input  32  store data (rt register value).
REQ-009 ack_o  output  1  one-cycle completion pulse.
REQ-010 rdata_o  output  32  load result, valid in the ack cycle, held until the next load completes.
REQ-011 stall_o  output  1  pipeline freeze to PC, IF/ID and later pipeline registers.
REQ-012 err_o  output  1  access fault flag, valid only in the ack cycle.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and RESP.
REQ-014 IDLE with req_i=1 at an edge SHALL latch we_i, addr_i and wdata_i, load counter with LATENCY-1, and enter BUSY.
REQ-015 IDLE with req_i=0 SHALL remain in IDLE.
REQ-016 BUSY with counter>0 SHALL decrement the counter.
REQ-017 BUSY with counter=0 SHALL perform the latched access and enter RESP.
REQ-018 RESP SHALL assert ack_o for exactly one cycle, ignore req_i, and enter IDLE at the next edge.
REQ-019 A request sampled at edge N SHALL produce ack_o high in the cycle following edge N+LATENCY.
REQ-020 A new request SHALL be accepted no earlier than the cycle after ack, giving a one-cycle bubble between back-to-back requests.
REQ-021 stall_o SHALL equal req_i AND NOT ack_o, combinationally: high from the request cycle through the cycle before ack, low in the ack cycle.
REQ-022 The word index SHALL be addr[log2(DEPTH)+1:2].
REQ-023 A store SHALL write the full word; a load SHALL update rdata_o with the stored word.
REQ-024 A fault SHALL be flagged when addr[1:0]!=0 or addr[31:2]>=DEPTH.
REQ-025 A faulting access SHALL keep the normal latency and assert err_o with ack_o, leave memory unchanged, and not update rdata_o.
REQ-026 A load from a never-written word SHALL return 0, because storage is zeroed at reset.
REQ-027 A store followed by a load to the same word SHALL return the stored data; there is no write buffer and no forwarding hazard.
REQ-028 req_i dropped before ack is a protocol violation; the access SHALL still complete and ack SHALL still pulse.

Reset
REQ-029 rst_i=0 at an edge SHALL force IDLE, counter=0, ack_o=0, err_o=0, rdata_o=0 and all storage words=0.
REQ-030 A reset in BUSY SHALL drop the pending access: no write, no ack.
REQ-031 stall_o SHALL follow REQ-021 during reset; the CPU is held in reset by the same rst_i.

Structure
REQ-032 Package dmem_pkg SHALL hold the state enum, LATENCY and DEPTH defaults, and the index-width constant.
REQ-033 Storage SHALL be sub-module dmem_array, with synchronous write, asynchronous read and synchronous clear.
REQ-034 The FSM, counter, fault check and output registers SHALL reside in dmem_responder.

Verification
REQ-035 Reset release, no req -> ack_o=0, stall_o=0, rdata_o=0 indefinitely.
REQ-036 LATENCY=4: store addr 0x8 data 0xDEADBEEF at edge N -> ack in cycle after N+4, err_o=0; then load 0x8 -> rdata_o=0xDEADBEEF.
REQ-037 Load addr 0x6 (misaligned) and addr 0x80 (DEPTH=32, out of range) -> ack with err_o=1 after 4 cycles, rdata_o unchanged, memory unchanged.
REQ-038 Back-to-back store 0x0=0x1 and load 0x0 with req held -> stall_o high 4 cycles per access, one-cycle bubble, load returns 0x1.
REQ-039 Store 0xC=0x55 then rst_i=0 two cycles after request -> no ack; after reset, load 0xC returns 0.
REQ-040 LATENCY=1: load 0x4 -> ack in cycle after N+1, and stall_o high exactly one cycle.
